// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: bus widths, broadcast/slot records and requester indices.
package cdb_arbiter_pkg;

   localparam int unsigned ROB_TAG_LEN = 5;
   localparam int unsigned XLEN        = 32;
   localparam int unsigned NUM_CDB_REQ = 4;

   typedef struct packed {
      logic                   valid;
      logic [ROB_TAG_LEN-1:0] rob_tag;
      logic [XLEN-1:0]        value;
   } CDB_DATA;

   typedef struct packed {
      logic                   valid;
      logic [ROB_TAG_LEN-1:0] rob_tag;
      logic [XLEN-1:0]        value;
   } CDB_REQ;

   typedef enum logic [1:0] {
      ALU_REQ  = 2'd0,
      MULT_REQ = 2'd1,
      LOAD_REQ = 2'd2,
      BR_REQ   = 2'd3
   } cdb_req_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester handshake and CDB broadcast signals shared by the functional units and the arbiter.
interface cdb_arbiter_if
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_CDB_REQ
);
   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]                  req_valid;
   logic [NUM_REQ-1:0][ROB_TAG_LEN-1:0] req_rob_tag;
   logic [NUM_REQ-1:0][XLEN-1:0]        req_value;
   logic [NUM_REQ-1:0]                  req_ready;
   CDB_DATA                             cdb_data;
   logic [IDX_W-1:0]                    cdb_src;

   modport master (
      output req_valid, req_rob_tag, req_value,
      input  req_ready, cdb_data, cdb_src
   );

   modport slave (
      input  req_valid, req_rob_tag, req_value,
      output req_ready, cdb_data, cdb_src
   );

endinterface

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping modulo N.
module rr_arbiter #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     grant_o,
   output logic [IDX_W-1:0] grant_idx_o
);

   int unsigned idx;
   logic        found;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      idx         = 0;
      for (int unsigned k = 0; k < N; k++) begin
         // explicit wrap so non-power-of-two N never aliases
         idx = 32'(ptr_i) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (!found && req_i[idx]) begin
            found       = 1'b1;
            grant_o[idx] = 1'b1;
            grant_idx_o = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding slot per functional unit, round-robin drain into a registered broadcast.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ     = NUM_CDB_REQ,
   parameter int unsigned REQ_IDX_LEN = $clog2(NUM_REQ)
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         flush,
   cdb_arbiter_if.slave bus
);

   CDB_REQ                 slot_q [NUM_REQ];
   CDB_REQ                 slot_d [NUM_REQ];
   logic [REQ_IDX_LEN-1:0] rr_ptr_q, rr_ptr_d;
   CDB_DATA                cdb_q, cdb_d;
   logic [REQ_IDX_LEN-1:0] cdb_src_q, cdb_src_d;

   logic [NUM_REQ-1:0]     slot_vld;
   logic [NUM_REQ-1:0]     grant;
   logic [REQ_IDX_LEN-1:0] grant_idx;
   logic [NUM_REQ-1:0]     ready;

   always_comb begin
      slot_vld = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         slot_vld[i] = slot_q[i].valid;
      end
   end

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (REQ_IDX_LEN)
   ) u_rr (
      .req_i       (slot_vld),
      .ptr_i       (rr_ptr_q),
      .grant_o     (grant),
      .grant_idx_o (grant_idx)
   );

   // a slot being drained this cycle can be refilled in the same cycle
   assign ready         = reset ? (~slot_vld | grant) : '0;
   assign bus.req_ready = ready;
   assign bus.cdb_data  = cdb_q;
   assign bus.cdb_src   = cdb_src_q;

   always_comb begin
      slot_d      = slot_q;
      rr_ptr_d    = rr_ptr_q;
      cdb_d       = cdb_q;
      cdb_d.valid = 1'b0;
      cdb_src_d   = cdb_src_q;

      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            slot_d[i].valid = 1'b0;
         end
         if (bus.req_valid[i] && ready[i]) begin
            slot_d[i].valid   = 1'b1;
            slot_d[i].rob_tag = bus.req_rob_tag[i];
            slot_d[i].value   = bus.req_value[i];
         end
      end

      if (|grant) begin
         cdb_d.valid   = 1'b1;
         cdb_d.rob_tag = slot_q[grant_idx].rob_tag;
         cdb_d.value   = slot_q[grant_idx].value;
         cdb_src_d     = grant_idx;
         rr_ptr_d      = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
      end

      // flush squashes held results and the broadcast that would have left this edge
      if (flush) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            slot_d[i].valid = 1'b0;
         end
         cdb_d       = cdb_q;
         cdb_d.valid = 1'b0;
         cdb_src_d   = cdb_src_q;
         rr_ptr_d    = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            slot_q[i] <= '0;
         end
         rr_ptr_q  <= '0;
         cdb_q     <= '0;
         cdb_src_q <= '0;
      end else begin
         slot_q    <= slot_d;
         rr_ptr_q  <= rr_ptr_d;
         cdb_q     <= cdb_d;
         cdb_src_q <= cdb_src_d;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: 4- and 3-requester instances, broadcasts checked against a scoreboard.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   typedef struct packed {
      CDB_DATA    d;
      logic [1:0] src;
   } exp_t;

   logic clock;
   logic reset;
   logic flush;

   int unsigned total = 0;
   int unsigned bad   = 0;

   exp_t q4[$];
   exp_t q3[$];

   cdb_arbiter_if #(.NUM_REQ(4)) bus4 ();
   cdb_arbiter_if #(.NUM_REQ(3)) bus3 ();

   cdb_arbiter #(.NUM_REQ(4)) u_dut4 (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .bus   (bus4.slave)
   );

   cdb_arbiter #(.NUM_REQ(3)) u_dut3 (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .bus   (bus3.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic exp_t mk(input logic [4:0] tag, input logic [31:0] val, input logic [1:0] src);
      exp_t e;
      e.d.valid   = 1'b1;
      e.d.rob_tag = tag;
      e.d.value   = val;
      e.src       = src;
      return e;
   endfunction

   // scoreboard: every valid broadcast must match the oldest expected entry
   always @(negedge clock) begin
      if (bus4.cdb_data.valid === 1'b1) begin
         total++;
         assert (q4.size() != 0) else begin
            bad++;
            $error("FAIL bcast4_unexpected got=%h exp=none", {bus4.cdb_data, bus4.cdb_src});
         end
         if (q4.size() != 0) begin
            exp_t e;
            e = q4.pop_front();
            total++;
            assert ({bus4.cdb_data, bus4.cdb_src} === e) else begin
               bad++;
               $error("FAIL bcast4 got=%h exp=%h", {bus4.cdb_data, bus4.cdb_src}, e);
            end
         end
      end
      if (bus3.cdb_data.valid === 1'b1) begin
         total++;
         assert (q3.size() != 0) else begin
            bad++;
            $error("FAIL bcast3_unexpected got=%h exp=none", {bus3.cdb_data, bus3.cdb_src});
         end
         if (q3.size() != 0) begin
            exp_t e;
            e = q3.pop_front();
            total++;
            assert ({bus3.cdb_data, bus3.cdb_src} === e) else begin
               bad++;
               $error("FAIL bcast3 got=%h exp=%h", {bus3.cdb_data, bus3.cdb_src}, e);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drain(input string tag);
      int unsigned n;
      n = 0;
      while ((q4.size() != 0 || q3.size() != 0) && n < 40) begin
         tick();
         n++;
      end
      tick();
      chk(tag, 64'(q4.size() + q3.size()), 64'd0);
      chk({tag, "_idle4"}, 64'(bus4.cdb_data.valid), 64'd0);
   endtask

   initial begin
      logic [4:0] t1, t3;
      logic       e1, e3;

      reset = 1'b0;
      flush = 1'b0;
      bus4.req_valid   = '1;
      bus4.req_rob_tag = '0;
      bus4.req_value   = '0;
      bus3.req_valid   = '0;
      bus3.req_rob_tag = '0;
      bus3.req_value   = '0;
      for (int i = 0; i < 4; i++) begin
         bus4.req_rob_tag[i] = 5'(8 + i);
         bus4.req_value[i]   = 32'h1000 + 32'(i);
      end

      // reset held with all requests presented
      tick();
      tick();
      chk("rst_ready4", 64'(bus4.req_ready), 64'h0);
      chk("rst_ready3", 64'(bus3.req_ready), 64'h0);
      chk("rst_cdb4", 64'(bus4.cdb_data), 64'h0);
      chk("rst_src4", 64'(bus4.cdb_src), 64'h0);

      // release: all four accepted together, drained 0,1,2,3
      reset = 1'b1;
      #1;
      chk("rel_ready4", 64'(bus4.req_ready), 64'hF);
      for (int i = 0; i < 4; i++) begin
         q4.push_back(mk(5'(8 + i), 32'h1000 + 32'(i), 2'(i)));
      end
      tick();
      bus4.req_valid = '0;
      drain("contention");
      chk("ptr_after_contention", 64'(u_dut4.rr_ptr_q), 64'd0);

      // fairness: requesters 1 and 3 stream continuously
      t1 = 5'd1;
      t3 = 5'd16;
      bus4.req_valid = 4'b1010;
      for (int k = 0; k < 8; k++) begin
         bus4.req_rob_tag[1] = t1;
         bus4.req_value[1]   = 32'hA000 + 32'(t1);
         bus4.req_rob_tag[3] = t3;
         bus4.req_value[3]   = 32'hA000 + 32'(t3);
         #1;
         e1 = (k == 0) || (k % 2 == 1);
         e3 = (k == 0) || (k % 2 == 0);
         chk($sformatf("fair_ready1_%0d", k), 64'(bus4.req_ready[1]), 64'(e1));
         chk($sformatf("fair_ready3_%0d", k), 64'(bus4.req_ready[3]), 64'(e3));
         if (e1) q4.push_back(mk(t1, 32'hA000 + 32'(t1), 2'd1));
         if (e3) q4.push_back(mk(t3, 32'hA000 + 32'(t3), 2'd3));
         tick();
         if (e1) t1++;
         if (e3) t3++;
      end
      bus4.req_valid = '0;
      drain("fairness");

      // single requester 2
      bus4.req_valid[2]   = 1'b1;
      bus4.req_rob_tag[2] = 5'd3;
      bus4.req_value[2]   = 32'hDEAD;
      q4.push_back(mk(5'd3, 32'hDEAD, 2'd2));
      tick();
      bus4.req_valid = '0;
      tick();
      chk("single_valid", 64'(bus4.cdb_data.valid), 64'd1);
      chk("single_src", 64'(bus4.cdb_src), 64'd2);
      tick();
      chk("single_after", 64'(bus4.cdb_data.valid), 64'd0);
      drain("single");

      // flush with slots 0 and 2 held and requester 1 presenting tag 5
      bus4.req_valid      = 4'b0101;
      bus4.req_rob_tag[0] = 5'd20;
      bus4.req_rob_tag[2] = 5'd22;
      tick();
      bus4.req_valid      = 4'b0010;
      bus4.req_rob_tag[1] = 5'd5;
      bus4.req_value[1]   = 32'h5555;
      flush = 1'b1;
      #1;
      chk("flush_ready4", 64'(bus4.req_ready), 64'b1011);
      tick();
      flush = 1'b0;
      bus4.req_valid = '0;
      chk("flush_valid", 64'(bus4.cdb_data.valid), 64'd0);
      chk("flush_empty", 64'(bus4.req_ready), 64'hF);
      chk("flush_ptr", 64'(u_dut4.rr_ptr_q), 64'd0);
      drain("flush");

      // odd size: drive pointer to 2, then wrap 2 -> 0 -> 1
      bus3.req_valid      = 3'b010;
      bus3.req_rob_tag[1] = 5'd7;
      bus3.req_value[1]   = 32'h0707;
      q3.push_back(mk(5'd7, 32'h0707, 2'd1));
      tick();
      bus3.req_valid = '0;
      drain("wrap_setup");
      chk("wrap_ptr2", 64'(u_dut3.rr_ptr_q), 64'd2);
      bus3.req_valid      = 3'b101;
      bus3.req_rob_tag[0] = 5'd10;
      bus3.req_value[0]   = 32'h0A0A;
      bus3.req_rob_tag[2] = 5'd12;
      bus3.req_value[2]   = 32'h0C0C;
      q3.push_back(mk(5'd12, 32'h0C0C, 2'd2));
      q3.push_back(mk(5'd10, 32'h0A0A, 2'd0));
      tick();
      bus3.req_valid = '0;
      tick();
      chk("wrap_ptr0", 64'(u_dut3.rr_ptr_q), 64'd0);
      tick();
      chk("wrap_ptr1", 64'(u_dut3.rr_ptr_q), 64'd1);
      drain("wrap");

      // reset mid-stream: held results and pending broadcast vanish
      bus4.req_valid = '1;
      tick();
      bus4.req_valid = '0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      chk("midrst_cdb", 64'(bus4.cdb_data), 64'h0);
      chk("midrst_empty", 64'(bus4.req_ready), 64'hF);
      for (int i = 0; i < 4; i++) tick();
      drain("midrst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between NUM_REQ functional-unit requesters (ALU, multiplier, load unit, branch unit).
- Each requester gets a one-entry holding slot; a round-robin arbiter picks one occupied slot per cycle and drives it as a registered CDB_DATA broadcast.
- The broadcast is consumed by the reorder buffer, the reservation stations and dependent stores.
- A flush input discards all in-flight results on mispredict recovery.

Parameters:
- NUM_REQ, 4, number of requesting functional units (>=2).
- REQ_IDX_LEN, $clog2(NUM_REQ), width of requester index.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low; state is reset when reset==0 at posedge.
- flush  in  1  synchronous squash of all held results.
- req_valid  in  [NUM_REQ]  requester i presents a result.
- req_rob_tag  in  [NUM_REQ][`ROB_TAG_LEN]  ROB tag of result i.
- req_value  in  [NUM_REQ][`XLEN]  value (or store address) of result i.
- req_ready  out  [NUM_REQ]  slot i can accept this cycle.
- cdb_data  out  CDB_DATA  registered broadcast {valid, rob_tag, value}.
- cdb_src  out  REQ_IDX_LEN  index of the requester that produced the current cdb_data (debug/perf).

Behaviour:
- State: slot_valid/slot_tag/slot_value per requester; rr_ptr (REQ_IDX_LEN); registered cdb_data and cdb_src.
- Reset (reset==0 at posedge): all slot_valid=0, rr_ptr=0, cdb_data='0 (valid=0, tag=0, value=0), cdb_src=0.
- req_ready is forced to 0 while reset==0.
- Grant (combinational): scan slots starting at rr_ptr, wrapping modulo NUM_REQ. The first slot_valid wins; grant is one-hot or all-zero.
- req_ready[i] = !slot_valid[i] || grant[i]. A slot being drained this cycle may be refilled in the same cycle.
- Accept: req_valid[i] && req_ready[i] at posedge loads the slot with the tag and value and sets slot_valid[i]=1.
- Request made while not ready: the requester must hold req_valid and its data stable until accepted.
- Broadcast on a grant to w: at posedge cdb_data <= {1, slot_tag[w], slot_value[w]}, cdb_src <= w, rr_ptr <= (w+1) mod NUM_REQ.
- Broadcast on a granted slot that is not refilled in the same cycle: slot_valid[w] is cleared.
- No grant: cdb_data.valid <= 0. tag, value, cdb_src and rr_ptr hold their previous values.
- Latency: result accepted at edge E, broadcast registered at edge E+1, visible during the following cycle. With no contention the bus sustains 1 result/cycle per requester.
- Fairness: an occupied slot is broadcast within NUM_REQ grants. No requester may win twice while another slot is continuously occupied.
- Simultaneous refill and drain of slot i in one cycle: the new data is stored and the old data is broadcast. No loss or duplication.
- Flush (reset high, flush==1 at posedge): all slot_valid=0, cdb_data.valid=0, rr_ptr=0.
  - Requests presented in the flush cycle are dropped.
  - req_ready stays driven normally.
  - reset has priority over flush.
- Reset asserted mid-stream: occupied slots and the pending broadcast are discarded with no partial output.
- rr_ptr wraps from NUM_REQ-1 to 0. NUM_REQ need not be a power of two; the wrap is an explicit compare, not truncation.

Decomposition:
- Shared package sys_defs: CDB_DATA (existing), `ROB_TAG_LEN, `XLEN.
- Add to sys_defs:
  - `NUM_CDB_REQ (default 4).
  - CDB_REQ typedef {valid, rob_tag, value} for slot storage.
  - Symbolic requester indices (ALU_REQ, MULT_REQ, LOAD_REQ, BR_REQ).
- Sub-module rr_arbiter: parameter N; inputs req[N] and ptr; output one-hot grant[N] and grant_idx. Purely combinational and reusable for other shared resources (e.g. memory port).

Test Plan:
- Reset: hold reset=0 two cycles with all req_valid=1 -> req_ready=0, cdb_data.valid=0. After release, first accept, then a broadcast from requester 0.
- Single requester: req 2 presents tag=3, value=0xDEAD at edge E -> cdb_data={1,3,0xDEAD}, cdb_src=2 after E+1. Next cycle valid=0.
- Contention: all four requesters present one result each in the same cycle, rr_ptr=0 -> broadcasts in order 0,1,2,3 on four consecutive cycles, then valid=0. rr_ptr ends at 0.
- Back-to-back fairness: requesters 1 and 3 hold req_valid high continuously with incrementing tags -> broadcasts alternate 1,3,1,3. req_ready[i] is high on each drain cycle, so each requester sustains 1 result per 2 cycles.
- Flush: slots 0 and 2 occupied and req 1 presenting tag=5 when flush=1 -> next cycle cdb_data.valid=0, all slots empty. Tag 5 is never broadcast.
- Wrap/odd size (NUM_REQ=3): rr_ptr=2, slots 0 and 2 occupied -> 2 is broadcast first, then 0. rr_ptr goes 2->0->1.
